// File: rtl/reg_cfg_master.sv
// reg_cfg_master: queues 32-bit configuration commands in a small FIFO and
// plays them out one at a time on a simple strobe-based register bus.
// Write-verify commands write and then read back the same address. A
// mismatch on the read-back is flagged on the response and counted.
module reg_cfg_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_data,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [13:0]          addr,
  output logic [15:0]          write_data,
  input  logic [15:0]          read_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [13:0]          rsp_addr,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WV  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [13:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO: pointers carry one extra wrap bit so full and empty can
  // be told apart without a separate occupancy counter.
  // ---------------------------------------------------------------------
  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  state_t        state;
  cmd_t          cur;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // The FSM takes the head whenever it is idle and something is queued.
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign busy      = !empty || (state != IDLE);

  // Storage array needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_t'(cmd_data);
  end

  // Pointer update; push and pop in the same cycle leave occupancy as is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Bus sequencer. All bus and response outputs are registered here so the
  // strobes are glitch-free and addr/write_data hold their last value while
  // idle. Strobes are set on the edge entering WR/RD and cleared on the edge
  // leaving it, which makes each exactly one cycle wide.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            cur <= head;
            case (head.op)
              OP_WR, OP_WV: begin
                state      <= WR;
                wr_en      <= 1'b1;
                addr       <= head.addr;
                write_data <= head.data;
              end
              OP_RD: begin
                state <= RD;
                rd_en <= 1'b1;
                addr  <= head.addr;
              end
              default: begin
                // Reserved op: no bus cycle, straight to an error response.
                state     <= RSP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_addr  <= head.addr;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        WR: begin
          wr_en <= 1'b0;
          if (cur.op == OP_WV) begin
            // Read back the same address on the very next cycle.
            state <= RD;
            rd_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        RD: begin
          // read_data is combinational from addr, valid by end of cycle.
          rd_en     <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_data  <= read_data;
          rsp_addr  <= cur.addr;
          rsp_err   <= (cur.op == OP_WV) && (read_data != cur.data);
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (rsp_err && (err_cnt != {ERR_CNT_W{1'b1}}))
              err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // OP_RSV is handled by the default arm above; keep the name referenced.
  logic unused_rsv;
  assign unused_rsv = (OP_RSV == 2'b11);

endmodule

// File: tb/tb_reg_cfg_master.sv
// Directed bench for reg_cfg_master: responses are checked against a
// scoreboard queue filled when commands are pushed; bus strobes are checked
// for timing and mutual exclusion.
module tb_reg_cfg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_en;
  logic        rd_en;
  logic [13:0] addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [13:0] rsp_addr;
  logic        rsp_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int wr_n  = 0;
  int rd_n  = 0;

  typedef struct packed {
    logic [13:0] a;
    logic [15:0] d;
    logic        e;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;

  reg_cfg_master #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
    .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file model: 0x304 reads 0x0042, 0x305 is read-only zero.
  function automatic logic [15:0] model(input logic [13:0] a);
    case (a)
      14'h304: model = 16'h0042;
      14'h305: model = 16'h0000;
      default: model = {2'b00, a} ^ 16'h5A00;
    endcase
  endfunction

  assign read_data = model(addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Response monitor and strobe watcher.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en || rd_en) chk("strobe_excl", {31'b0, wr_en & rd_en}, 32'd0);
      if (wr_en) wr_n++;
      if (rd_en) rd_n++;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", {18'b0, rsp_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_addr", {18'b0, rsp_addr}, {18'b0, mon_e.a});
          chk("rsp_data", {16'b0, rsp_data}, {16'b0, mon_e.d});
          chk("rsp_err",  {31'b0, rsp_err},  {31'b0, mon_e.e});
        end
      end
    end
  end

  // Offer one command; returns #1 after the accepting edge.
  task automatic push(input logic [31:0] d, input bit exp_rsp, input rsp_t exp);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", {31'b0, cmd_ready}, 32'd1);
    end else begin
      cmd_valid = 1'b1;
      cmd_data  = d;
      if (exp_rsp) sb_q.push_back(exp);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'b0, (busy || sb_q.size() != 0)}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_en"},     {31'b0, wr_en},       32'd0);
    chk({tag, "_rd_en"},     {31'b0, rd_en},       32'd0);
    chk({tag, "_addr"},      {18'b0, addr},        32'd0);
    chk({tag, "_wdata"},     {16'b0, write_data},  32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid},   32'd0);
    chk({tag, "_rsp_data"},  {16'b0, rsp_data},    32'd0);
    chk({tag, "_rsp_addr"},  {18'b0, rsp_addr},    32'd0);
    chk({tag, "_rsp_err"},   {31'b0, rsp_err},     32'd0);
    chk({tag, "_err_cnt"},   {24'b0, err_cnt},     32'd0);
    chk({tag, "_busy"},      {31'b0, busy},        32'd0);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready},   32'd1);
  endtask

  initial begin
    int w0, r0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    #2 rst = 1'b0;
    #10 chk_reset_outs("por");
    @(negedge clk) rst = 1'b1;

    // Plain write: strobe two edges after the push edge, no response.
    w0 = wr_n;
    push({2'b00, 14'h301, 16'hABCD}, 1'b0, '0);
    chk("wr_not_early", {31'b0, wr_en}, 32'd0);
    @(posedge clk); #1;
    chk("wr_strobe", {31'b0, wr_en}, 32'd1);
    chk("wr_addr",   {18'b0, addr}, 32'h301);
    chk("wr_wdata",  {16'b0, write_data}, 32'hABCD);
    @(posedge clk); #1;
    chk("wr_one_cycle", {31'b0, wr_en}, 32'd0);
    repeat (3) @(negedge clk);
    chk("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("wr_pulses", wr_n - w0, 32'd1);
    chk("wr_addr_hold", {18'b0, addr}, 32'h301);

    // Plain read.
    r0 = rd_n;
    push({2'b01, 14'h304, 16'h0000}, 1'b1, '{a:14'h304, d:16'h0042, e:1'b0});
    wait_idle("rd");
    chk("rd_pulses", rd_n - r0, 32'd1);

    // Write-verify mismatch: wr then rd on consecutive cycles.
    push({2'b10, 14'h305, 16'h1234}, 1'b1, '{a:14'h305, d:16'h0000, e:1'b1});
    @(posedge clk); #1;
    chk("wv_wr", {30'b0, wr_en, rd_en}, 32'd2);
    @(posedge clk); #1;
    chk("wv_rd", {30'b0, wr_en, rd_en}, 32'd1);
    @(posedge clk); #1;
    chk("wv_rsp", {30'b0, rsp_valid, rsp_err}, 32'd3);
    wait_idle("wv");
    chk("wv_err_cnt", {24'b0, err_cnt}, 32'd1);

    // Write-verify match and reserved op.
    push({2'b10, 14'h310, model(14'h310)}, 1'b1, '{a:14'h310, d:model(14'h310), e:1'b0});
    push({2'b11, 14'h3AA, 16'h7777}, 1'b1, '{a:14'h3AA, d:16'h0000, e:1'b1});
    wait_idle("rsv");
    chk("rsv_err_cnt", {24'b0, err_cnt}, 32'd2);

    // Backpressure: 1 held in RSP + 4 queued fills everything.
    rsp_ready = 1'b0;
    r0 = rd_n;
    for (int i = 0; i < 5; i++) begin
      logic [13:0] a;
      a = 14'h320 + 14'(i);
      push({2'b01, a, 16'h0000}, 1'b1, '{a:a, d:model(a), e:1'b0});
    end
    @(negedge clk);
    chk("bp_full", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = {2'b01, 14'h325, 16'h0000};
    repeat (5) @(negedge clk);
    chk("bp_still_full", {31'b0, cmd_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_hold_addr",  {18'b0, rsp_addr}, 32'h320);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("bp");
    chk("bp_rd_pulses", rd_n - r0, 32'd5);

    // Saturation of the mismatch counter.
    for (int i = 0; i < 260; i++)
      push({2'b10, 14'h305, 16'h1234}, 1'b1, '{a:14'h305, d:16'h0000, e:1'b1});
    wait_idle("sat");
    chk("sat_err_cnt", {24'b0, err_cnt}, 32'hFF);

    // Reset while a read is on the bus with two writes still queued.
    push({2'b00, 14'h330, 16'h1111}, 1'b0, '0);
    push({2'b01, 14'h340, 16'h0000}, 1'b0, '0);
    push({2'b00, 14'h341, 16'h2222}, 1'b0, '0);
    push({2'b00, 14'h342, 16'h3333}, 1'b0, '0);
    chk("rst_mid_rd", {31'b0, rd_en}, 32'd1);
    rst = 1'b0;
    #1 chk_reset_outs("rst");
    sb_q.delete();
    w0 = wr_n;
    r0 = rd_n;
    @(negedge clk) rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_wr", wr_n - w0, 32'd0);
    chk("rst_no_rd", rd_n - r0, 32'd0);
    chk("rst_idle",  {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_cfg_master.md
REG_CFG_MASTER -- requirements
Module: reg_cfg_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ERR_CNT_W, default 8, width of the verify-mismatch counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command word offered.
REQ-006 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-007 SHALL have port cmd_data  input  32  [31:30] op (00 write, 01 read, 10 write-verify, 11 reserved), [29:16] addr, [15:0] data.
REQ-008 SHALL have port wr_en  output  1  register-bus write strobe.
REQ-009 SHALL have port rd_en  output  1  register-bus read strobe.
REQ-010 SHALL have port addr  output  14  register-bus address.
REQ-011 SHALL have port write_data  output  16  register-bus write data.
REQ-012 SHALL have port read_data  input  16  register-bus read data, combinational from addr.
REQ-013 SHALL have port rsp_valid  output  1  response held.
REQ-014 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-015 SHALL have port rsp_data  output  16  captured read data.
REQ-016 SHALL have port rsp_addr  output  14  address of the responded command.
REQ-017 SHALL have port rsp_err  output  1  write-verify mismatch, or reserved op.
REQ-018 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of rsp_err responses.
REQ-019 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-020 SHALL push cmd_data into the FIFO on any cycle with cmd_valid && cmd_ready; cmd_ready = !full.
REQ-021 SHALL allow push and pop in the same cycle when not full; occupancy then stays unchanged.
REQ-022 SHALL implement FSM states IDLE, WR, RD, RSP; registered outputs wr_en, rd_en, addr, write_data.
REQ-023 SHALL leave IDLE when the FIFO is non-empty, popping the head: op 00/10 -> WR; op 01 -> RD; op 11 -> RSP with rsp_err=1, rsp_data=0.
REQ-024 SHALL assert wr_en for exactly one cycle in WR, with addr and write_data from the command.
REQ-025 SHALL go WR -> IDLE for op 00, producing no response; WR -> RD for op 10, same addr.
REQ-026 SHALL assert rd_en for exactly one cycle in RD and capture read_data at the end of that cycle into rsp_data, then -> RSP.
REQ-027 SHALL, for op 10, set rsp_err=1 when captured read_data != command data; otherwise 0. Op 01 SHALL always give rsp_err=0.
REQ-028 SHALL hold rsp_valid, rsp_data, rsp_addr, rsp_err stable in RSP until rsp_valid && rsp_ready, then -> IDLE.
REQ-029 SHALL increment err_cnt once per accepted rsp_err=1 response; saturate at all-ones, no wrap.
REQ-030 SHALL keep wr_en and rd_en never high together; addr and write_data SHALL hold their last values while idle.
REQ-031 SHALL give latency: command pushed at edge N into an empty FIFO with FSM IDLE -> strobe high in cycle N+2.
REQ-032 SHALL keep commands strictly in order, one bus transaction at a time, none dropped while cmd_ready=1.

Reset
REQ-033 SHALL, on rst low, asynchronously: flush the FIFO and enter IDLE; all outputs 0 except cmd_ready=1.
REQ-034 SHALL discard any in-flight command or pending response on reset; no strobe after rst deasserts until a new push.

Verification
REQ-035 Write: push {00,14'h301,16'hABCD} -> single wr_en pulse at N+2, addr=14'h301, write_data=16'hABCD, no rsp_valid.
REQ-036 Read: model returns 16'h0042 at 14'h304; push {01,14'h304,x} -> single rd_en pulse; rsp_valid with rsp_data=16'h0042, rsp_addr=14'h304, rsp_err=0.
REQ-037 Verify mismatch: read-only register returns 16'h0000; push {10,14'h305,16'h1234} -> wr_en then rd_en on consecutive cycles; rsp_err=1; err_cnt 0->1.
REQ-038 Backpressure/full: hold rsp_ready=0, push 6 reads -> cmd_ready=0 after the FIFO fills (4 queued + 1 in RSP); release -> 5 responses in order.
REQ-039 Saturation: 260 verify mismatches -> err_cnt stops at 8'hFF.
REQ-040 Reset mid-RD, with 2 queued commands -> outputs 0, FIFO empty, busy=0, no strobe after release.
